// File: rtl/matrix_reg_slave.sv
// matrix_reg_slave: Wishbone responder for the LED matrix control registers.
// Holds a double-buffered frame base address (shadow -> active at the next
// frame boundary), the enable/brightness control byte and a 16-bit frame
// counter with an atomic low/high read snapshot.

`ifndef MATRIX_START
`define MATRIX_START 16'h0040
`endif

module matrix_reg_slave #(
  parameter int                         ADDRESS_WIDTH    = 16,
  parameter int                         DATA_WIDTH       = 8,   // only 8 is supported
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR        = `MATRIX_START,
  parameter int                         WAIT_STATES      = 0,   // 0..15
  parameter logic [15:0]                RESET_FRAME_ADDR = 16'h0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic [DATA_WIDTH-1:0]    dat_o,
  input  logic                     we_i,
  input  logic                     sel_i,
  input  logic                     stb_i,
  input  logic                     cyc_i,
  output logic                     ack_o,
  input  logic [2:0]               cti_i,
  input  logic                     frame_start,
  output logic [15:0]              frame_addr,
  output logic                     enable,
  output logic [3:0]               brightness,
  output logic                     update_pulse
);

  // Register indices within the 16-byte window.
  localparam logic [3:0] REG_ADDR_L  = 4'h0;
  localparam logic [3:0] REG_ADDR_H  = 4'h1;
  localparam logic [3:0] REG_CONTROL = 4'h2;
  localparam logic [3:0] REG_STATUS  = 4'h3;
  localparam logic [3:0] REG_COUNT_L = 4'h4;
  localparam logic [3:0] REG_COUNT_H = 4'h5;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        burst_q;      // the beat just accepted was an incrementing-burst beat

  logic [15:0] shadow;
  logic        pending;
  logic [15:0] count;
  logic [7:0]  snapshot;

  logic        select;
  logic        do_access;
  logic [3:0]  idx;
  logic        is_write;
  logic        is_read;
  logic        shadow_wr;
  logic [7:0]  rd_data;

  assign select = cyc_i & stb_i &
                  (adr_i[ADDRESS_WIDTH-1:4] == BASE_ADDR[ADDRESS_WIDTH-1:4]);
  assign idx    = adr_i[3:0];

  // Decide whether the current bus values form an access performed on this edge.
  // A zero-wait burst continues while the previously accepted beat was tagged
  // incrementing, so the beat carrying the end-of-burst tag is still accepted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    do_access = 1'b0;
    unique case (state)
      S_IDLE:  do_access = select && ZERO_WAIT;
      S_WAIT:  do_access = select && (wait_cnt == 4'd1);
      S_ACK:   do_access = select && burst_q && ZERO_WAIT;
      default: do_access = 1'b0;
    endcase
  end

  assign is_write  = do_access & we_i & sel_i;
  assign is_read   = do_access & ~we_i & sel_i;
  assign shadow_wr = is_write && ((idx == REG_ADDR_L) || (idx == REG_ADDR_H));

  // Read data multiplexer for the register window.
  always_comb begin
    rd_data = 8'h00;
    case (idx)
      REG_ADDR_L:  rd_data = shadow[7:0];
      REG_ADDR_H:  rd_data = shadow[15:8];
      REG_CONTROL: rd_data = {brightness, 3'b000, enable};
      REG_STATUS:  rd_data = {7'b0, pending};
      REG_COUNT_L: rd_data = count[7:0];
      REG_COUNT_H: rd_data = snapshot;
      default:     rd_data = 8'h00;
    endcase
  end

  // Bus handshake state machine with registered acknowledge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      burst_q  <= 1'b0;
      ack_o    <= 1'b0;
    end else begin
      ack_o <= do_access;
      if (do_access) begin
        burst_q <= (cti_i == CTI_INCR);
      end
      unique case (state)
        S_IDLE: begin
          if (select) begin
            if (ZERO_WAIT) begin
              state <= S_ACK;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (!select) begin
            state <= S_IDLE;          // master gave up: no access
          end else if (wait_cnt == 4'd1) begin
            state <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ACK: begin
          state <= do_access ? S_ACK : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file, frame-boundary commit and frame counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow       <= RESET_FRAME_ADDR;
      frame_addr   <= RESET_FRAME_ADDR;
      pending      <= 1'b0;
      enable       <= 1'b0;
      brightness   <= 4'd0;
      count        <= 16'd0;
      snapshot     <= 8'd0;
      dat_o        <= '0;
      update_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments mean a commit in the same cycle as a
      // shadow write sees the pre-write shadow, which is the intended behaviour.
      update_pulse <= frame_start & pending;
      if (frame_start && pending) begin
        frame_addr <= shadow;
      end

      if (shadow_wr) begin
        pending <= 1'b1;
      end else if (frame_start) begin
        pending <= 1'b0;
      end

      if (frame_start && enable) begin
        count <= count + 16'd1;
      end

      if (is_write) begin
        case (idx)
          REG_ADDR_L:  shadow[7:0]  <= dat_i;
          REG_ADDR_H:  shadow[15:8] <= dat_i;
          REG_CONTROL: begin
            enable     <= dat_i[0];
            brightness <= dat_i[7:4];
          end
          default: ;                  // read-only or unused: ignored
        endcase
      end

      if (is_read) begin
        dat_o <= rd_data;
        if (idx == REG_COUNT_L) begin
          snapshot <= count[15:8];    // freeze upper byte for an atomic pair
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_reg_slave.sv
// Self-checking bench for matrix_reg_slave: a zero-wait instance exercised
// with classic and burst cycles, and a three-wait-state instance for the
// wait/abort handshake. Read expectations go through a scoreboard queue.

module tb_matrix_reg_slave;

  localparam logic [15:0] BASE = 16'h0040;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Zero-wait instance signals.
  logic [15:0] adr;
  logic [7:0]  dat_w, dat_r;
  logic        we, sel, stb, cyc, ack;
  logic [2:0]  cti;
  logic        frame_start;
  logic [15:0] frame_addr;
  logic        enable, update_pulse;
  logic [3:0]  brightness;

  // Wait-state instance signals.
  logic [15:0] adr1;
  logic [7:0]  dat1_w, dat1_r;
  logic        we1, sel1, stb1, cyc1, ack1;
  logic [2:0]  cti1;
  logic        frame_start1;
  logic [15:0] frame_addr1;
  logic        enable1, update_pulse1;
  logic [3:0]  brightness1;

  matrix_reg_slave #(
    .ADDRESS_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(BASE),
    .WAIT_STATES(0), .RESET_FRAME_ADDR(16'h0000)
  ) dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat_r),
    .we_i(we), .sel_i(sel), .stb_i(stb), .cyc_i(cyc), .ack_o(ack),
    .cti_i(cti), .frame_start(frame_start), .frame_addr(frame_addr),
    .enable(enable), .brightness(brightness), .update_pulse(update_pulse)
  );

  matrix_reg_slave #(
    .ADDRESS_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(BASE),
    .WAIT_STATES(3), .RESET_FRAME_ADDR(16'h0000)
  ) dut_w3 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr1), .dat_i(dat1_w), .dat_o(dat1_r),
    .we_i(we1), .sel_i(sel1), .stb_i(stb1), .cyc_i(cyc1), .ack_o(ack1),
    .cti_i(cti1), .frame_start(frame_start1), .frame_addr(frame_addr1),
    .enable(enable1), .brightness(brightness1), .update_pulse(update_pulse1)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       is_read;
    logic [3:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every ack of the zero-wait instance consumes one expectation.
  always @(negedge clk) begin
    if (!rst && ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_read) begin
          check($sformatf("read_reg%0h", e.idx), {24'd0, dat_r}, {24'd0, e.data});
        end
      end
    end
  end

  // Single classic access on the zero-wait instance; called on a falling edge.
  task automatic bus(input logic [3:0] idx, input logic w, input logic [7:0] wd,
                     input logic [7:0] exp_rd, input logic s = 1'b1,
                     input logic fs = 1'b0);
    int n;
    exp_q.push_back('{is_read: ~w & s, idx: idx, data: exp_rd});
    adr = BASE | {12'd0, idx}; we = w; dat_w = wd; sel = s; cti = 3'b000;
    cyc = 1'b1; stb = 1'b1; frame_start = fs;
    n = 0;
    do begin
      @(negedge clk);
      frame_start = 1'b0;
      n++;
    end while (!ack && n < 10);
    check($sformatf("ack_latency_reg%0h", idx), n, 1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  // Single access on the three-wait-state instance with direct checking.
  task automatic bus1(input logic [3:0] idx, input logic w, input logic [7:0] wd,
                      input logic [7:0] exp_rd);
    int n;
    adr1 = BASE | {12'd0, idx}; we1 = w; dat1_w = wd; sel1 = 1'b1;
    cyc1 = 1'b1; stb1 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack1 && n < 20);
    check($sformatf("w3_ack_latency_reg%0h", idx), n, 4);
    if (!w) check($sformatf("w3_read_reg%0h", idx), {24'd0, dat1_r}, {24'd0, exp_rd});
    cyc1 = 1'b0; stb1 = 1'b0; we1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    adr = '0; dat_w = '0; we = 0; sel = 0; stb = 0; cyc = 0; cti = '0; frame_start = 0;
    adr1 = '0; dat1_w = '0; we1 = 0; sel1 = 0; stb1 = 0; cyc1 = 0; cti1 = '0; frame_start1 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_frame_addr", {16'd0, frame_addr}, 32'h0000);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_enable", {31'd0, enable}, 32'd0);
    check("rst_brightness", {28'd0, brightness}, 32'd0);
    check("rst_update_pulse", {31'd0, update_pulse}, 32'd0);
    check("rst_dat_o", {24'd0, dat_r}, 32'd0);

    // Every register reads zero after reset.
    for (int i = 0; i < 16; i++) bus(4'(i), 1'b0, 8'h00, 8'h00);

    // Double-buffered address write and commit.
    bus(4'h0, 1'b1, 8'h34, 8'h00);
    bus(4'h1, 1'b1, 8'h12, 8'h00);
    check("frame_addr_before_commit", {16'd0, frame_addr}, 32'h0000);
    bus(4'h3, 1'b0, 8'h00, 8'h01);
    bus(4'h0, 1'b0, 8'h00, 8'h34);
    bus(4'h1, 1'b0, 8'h00, 8'h12);
    check("frame_addr_still_old", {16'd0, frame_addr}, 32'h0000);
    pulse_frame();
    check("frame_addr_commit", {16'd0, frame_addr}, 32'h1234);
    check("update_pulse_high", {31'd0, update_pulse}, 32'd1);
    @(negedge clk);
    check("update_pulse_one_cycle", {31'd0, update_pulse}, 32'd0);
    bus(4'h3, 1'b0, 8'h00, 8'h00);

    // Shadow write coinciding with frame_start.
    bus(4'h1, 1'b1, 8'h56, 8'h00);                      // shadow = 5634, pending
    bus(4'h0, 1'b1, 8'h78, 8'h00, 1'b1, 1'b1);          // commit 5634, shadow 5678
    check("same_cycle_commit_old", {16'd0, frame_addr}, 32'h5634);
    bus(4'h3, 1'b0, 8'h00, 8'h01);
    pulse_frame();
    check("same_cycle_next_commit", {16'd0, frame_addr}, 32'h5678);
    bus(4'h3, 1'b0, 8'h00, 8'h00);

    // Control register: reserved bits read back as zero.
    bus(4'h2, 1'b1, 8'hAF, 8'h00);
    check("enable_set", {31'd0, enable}, 32'd1);
    check("brightness_set", {28'd0, brightness}, 32'hA);
    bus(4'h2, 1'b0, 8'h00, 8'hA1);
    bus(4'h4, 1'b0, 8'h00, 8'h00);                      // disabled pulses did not count

    // Counter to 0xFFFF, then wrap.
    frame_start = 1'b1;
    repeat (65535) @(negedge clk);
    frame_start = 1'b0;
    bus(4'h4, 1'b0, 8'h00, 8'hFF);
    bus(4'h5, 1'b0, 8'h00, 8'hFF);
    pulse_frame();
    bus(4'h4, 1'b0, 8'h00, 8'h00);
    bus(4'h5, 1'b0, 8'h00, 8'h00);

    // Atomic pair: counter goes 0x00FF -> 0x0100 between the L and H reads.
    frame_start = 1'b1;
    repeat (255) @(negedge clk);
    frame_start = 1'b0;
    bus(4'h4, 1'b0, 8'h00, 8'hFF);
    pulse_frame();
    bus(4'h5, 1'b0, 8'h00, 8'h00);
    bus(4'h4, 1'b0, 8'h00, 8'h00);
    bus(4'h5, 1'b0, 8'h00, 8'h01);

    // Four-beat zero-wait burst write to 0x0..0x3.
    begin
      logic [7:0] bdata [4];
      logic [2:0] bcti  [4];
      bdata[0] = 8'h9A; bdata[1] = 8'hBC; bdata[2] = 8'h00; bdata[3] = 8'hFF;
      bcti[0] = 3'b010; bcti[1] = 3'b010; bcti[2] = 3'b010; bcti[3] = 3'b111;
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back('{is_read: 1'b0, idx: 4'(b), data: 8'h00});
        adr = BASE | 16'(b); we = 1'b1; dat_w = bdata[b]; sel = 1'b1;
        cti = bcti[b]; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        check($sformatf("burst_ack_beat%0d", b), {31'd0, ack}, 32'd1);
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
      @(negedge clk);
      check("burst_ack_low_after", {31'd0, ack}, 32'd0);
    end
    check("burst_disabled", {31'd0, enable}, 32'd0);
    bus(4'h3, 1'b0, 8'h00, 8'h01);
    bus(4'h0, 1'b0, 8'h00, 8'h9A);
    bus(4'h1, 1'b0, 8'h00, 8'hBC);
    bus(4'h2, 1'b0, 8'h00, 8'h00);

    // Byte select low and unused registers: acked, no effect.
    bus(4'h0, 1'b1, 8'h55, 8'h00, 1'b0);
    bus(4'h0, 1'b0, 8'h00, 8'h9A);
    bus(4'h6, 1'b1, 8'h77, 8'h00);
    bus(4'h6, 1'b0, 8'h00, 8'h00);

    // Wait-state instance: aborted access after two cycles.
    adr1 = BASE | 16'h0001; we1 = 1'b1; dat1_w = 8'hEE; sel1 = 1'b1;
    cyc1 = 1'b1; stb1 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("w3_abort_no_ack_held", {31'd0, ack1}, 32'd0);
    end
    cyc1 = 1'b0; stb1 = 1'b0; we1 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("w3_abort_no_ack_after", {31'd0, ack1}, 32'd0);
    end
    bus1(4'h3, 1'b0, 8'h00, 8'h00);
    bus1(4'h1, 1'b0, 8'h00, 8'h00);
    bus1(4'h1, 1'b1, 8'hEE, 8'h00);
    bus1(4'h1, 1'b0, 8'h00, 8'hEE);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
